// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Groups the request/response handshake and data signals of alu_sequencer.
//   master : requester/consumer side (drives the operation, takes the result)
//   slave  : the sequencer itself
//   Signals:
//     start_valid / start_ready   operation handshake
//     in1, in2, alu_control       operands and opcode
//     result_valid / result_ready result handshake
//     out, zero_flag, msb_flag, carry_flag  registered result and flags
//     busy                        high while an operation is in flight or held
interface alu_sequencer_if;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  alu_control;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] out;
    logic        zero_flag;
    logic        msb_flag;
    logic        carry_flag;
    logic        busy;

    modport master (
        output start_valid, in1, in2, alu_control, result_ready,
        input  start_ready, result_valid, out, zero_flag, msb_flag, carry_flag, busy
    );

    modport slave (
        input  start_valid, in1, in2, alu_control, result_ready,
        output start_ready, result_valid, out, zero_flag, msb_flag, carry_flag, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle 32-bit ALU with valid/ready handshakes on both sides.
//   Single-cycle ops: ADD, COMP (two's complement of B), AND, XOR.
//   Iterative ops: SLL/SRL/SRA move one bit per cycle; DIFF scans for the
//   lowest bit position where A and B differ, one bit per cycle.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : alu_sequencer_if.slave (handshakes, operands, result, flags, busy)
module alu_sequencer (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_COMP = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_SLL  = 3'd4;
    localparam logic [2:0] OP_SRL  = 3'd5;
    localparam logic [2:0] OP_SRA  = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;          // operand A; doubles as the shift register
    logic [31:0] b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;      // remaining shift amount, or DIFF scan index
    logic        sc_q, sc_d;        // last bit shifted out
    logic [31:0] out_q, out_d;
    logic        zero_q, zero_d;
    logic        msb_q, msb_d;
    logic        carry_q, carry_d;
    logic        start_ready_q, start_ready_d;
    logic        result_valid_q, result_valid_d;
    logic        busy_q, busy_d;

    logic        finish;
    logic [31:0] res;
    logic        res_carry;
    logic [32:0] sum;
    logic        is_shift;

    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign is_shift = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL) ||
                      (bus.alu_control == OP_SRA);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        sc_d      = sc_q;
        out_d     = out_q;
        zero_d    = zero_q;
        msb_d     = msb_q;
        carry_d   = carry_q;
        finish    = 1'b0;
        res       = 32'd0;
        res_carry = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.in1;
                    b_d     = bus.in2;
                    op_d    = bus.alu_control;
                    cnt_d   = is_shift ? bus.in2[4:0] : 5'd0;
                    sc_d    = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        finish    = 1'b1;
                        res       = sum[31:0];
                        res_carry = sum[32];
                    end
                    OP_COMP: begin
                        finish    = 1'b1;
                        res       = ~b_q + 32'd1;
                        res_carry = (b_q == 32'd0);
                    end
                    OP_AND: begin
                        finish = 1'b1;
                        res    = a_q & b_q;
                    end
                    OP_XOR: begin
                        finish = 1'b1;
                        res    = a_q ^ b_q;
                    end
                    OP_SLL, OP_SRL, OP_SRA: begin
                        if (cnt_q != 5'd0) begin
                            cnt_d = cnt_q - 5'd1;
                            if (op_q == OP_SLL) begin
                                a_d  = {a_q[30:0], 1'b0};
                                sc_d = a_q[31];
                            end else begin
                                // SRA refills with the sign bit, SRL with zero
                                a_d  = {(op_q == OP_SRA) ? a_q[31] : 1'b0, a_q[31:1]};
                                sc_d = a_q[0];
                            end
                        end else begin
                            finish    = 1'b1;
                            res       = a_q;
                            res_carry = sc_q;
                        end
                    end
                    default: begin  // DIFF
                        if (a_q[cnt_q] != b_q[cnt_q]) begin
                            finish = 1'b1;
                            res    = {27'd0, cnt_q};
                        end else if (cnt_q == 5'd31) begin
                            // no differing bit anywhere: report 32 after 32 cycles
                            finish = 1'b1;
                            res    = 32'd32;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                endcase
                if (finish) begin
                    state_d = DONE;
                    out_d   = res;
                    zero_d  = (res == 32'd0);
                    msb_d   = res[31];
                    carry_d = res_carry;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // handshake outputs are registered, decoded from the next state
        start_ready_d  = (state_d == IDLE);
        result_valid_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= 3'd0;
            a_q            <= 32'd0;
            b_q            <= 32'd0;
            cnt_q          <= 5'd0;
            sc_q           <= 1'b0;
            out_q          <= 32'd0;
            zero_q         <= 1'b1;
            msb_q          <= 1'b0;
            carry_q        <= 1'b0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            cnt_q          <= cnt_d;
            sc_q           <= sc_d;
            out_q          <= out_d;
            zero_q         <= zero_d;
            msb_q          <= msb_d;
            carry_q        <= carry_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.out          = out_q;
    assign bus.zero_flag    = zero_q;
    assign bus.msb_flag     = msb_q;
    assign bus.carry_flag   = carry_q;
endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the opcode definitions
    task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic c, output int lat);
        logic [63:0] t;
        logic [32:0] s;
        logic [31:0] x;
        int n;
        n   = int'(b[4:0]);
        c   = 1'b0;
        lat = 1;
        r   = 32'd0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            3'd1: begin r = 32'd0 - b; c = (b == 32'd0); end
            3'd2: r = a & b;
            3'd3: r = a ^ b;
            3'd4: begin t = {32'd0, a} << n; r = t[31:0]; c = t[32]; lat = n + 1; end
            3'd5: begin t = {a, 32'd0} >> n; r = t[63:32]; c = t[31]; lat = n + 1; end
            3'd6: begin t = {a, 32'd0}; t = $signed(t) >>> n; r = t[63:32]; c = t[31]; lat = n + 1; end
            default: begin
                x = a ^ b;
                r = 32'd32;
                lat = 32;
                for (int i = 31; i >= 0; i--) begin
                    if (x[i]) begin
                        r = i;
                        lat = i + 1;
                    end
                end
            end
        endcase
    endtask

    // Issue one operation (called #1 after a rising edge with the unit idle),
    // wait for the result, hold backpressure for bp cycles, then hand it off.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int bp);
        logic [31:0] er;
        logic        ec;
        int          elat;
        int          lat;
        ref_model(op, a, b, er, ec, elat);
        bus.start_valid = 1'b1;
        bus.in1 = a;
        bus.in2 = b;
        bus.alu_control = op;
        @(posedge clk); #1;
        check("start_ready_exec", 32'(bus.start_ready), 32'd0);
        lat = 0;
        while (lat < 40) begin
            // inputs after accept must not matter; result_ready outside DONE is ignored
            bus.start_valid  = 1'($urandom_range(0, 1));
            bus.in1          = $urandom;
            bus.in2          = $urandom;
            bus.alu_control  = 3'($urandom_range(0, 7));
            bus.result_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            if (bus.result_valid === 1'b1) break;
        end
        bus.result_ready = 1'b0;
        $display("op=%0d a=%h b=%h -> out=%h c=%b lat=%0d (model out=%h c=%b lat=%0d)",
                 op, a, b, bus.out, bus.carry_flag, lat, er, ec, elat);
        check("latency", lat, elat);
        check("out", bus.out, er);
        check("zero", 32'(bus.zero_flag), 32'(er == 32'd0));
        check("msb", 32'(bus.msb_flag), 32'(er[31]));
        check("carry", 32'(bus.carry_flag), 32'(ec));
        check("busy_done", 32'(bus.busy), 32'd1);
        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.result_valid), 32'd1);
            check("hold_out", bus.out, er);
            check("hold_flags", {29'd0, bus.zero_flag, bus.msb_flag, bus.carry_flag},
                  {29'd0, er == 32'd0, er[31], ec});
            check("hold_start_ready", 32'(bus.start_ready), 32'd0);
        end
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        check("idle_start_ready", 32'(bus.start_ready), 32'd1);
        check("idle_valid", 32'(bus.result_valid), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        if (bus.busy !== 1'b0) begin
            // unit is stuck; recover so the remaining steps still run
            rst = 1'b1; #2; rst = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.start_valid  = 1'b0;
        bus.in1          = 32'd0;
        bus.in2          = 32'd0;
        bus.alu_control  = 3'd0;
        bus.result_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", bus.out, 32'd0);
        check("rst_flags", {29'd0, bus.zero_flag, bus.msb_flag, bus.carry_flag}, 32'b100);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_start_ready", 32'(bus.start_ready), 32'd1);
        rst = 1'b0;

        // directed steps
        run_op(3'd0, 32'd8, 32'd9, 10);                  // backpressure on the first result
        run_op(3'd0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(3'd1, 32'h1234_5678, 32'd5, 1);
        run_op(3'd1, 32'h0, 32'd0, 0);
        run_op(3'd4, 32'd1023, 32'd3, 0);
        run_op(3'd6, 32'hFD0F_5DAA, 32'd5, 0);
        run_op(3'd5, 32'h8000_0001, 32'hFFFF_FFE0, 0);   // amount 0, upper bits ignored
        run_op(3'd4, 32'hC000_0000, 32'd31, 0);
        run_op(3'd6, 32'h8000_0000, 32'd31, 0);
        run_op(3'd7, 32'd13, 32'd11, 0);
        run_op(3'd7, 32'd7, 32'd7, 2);
        run_op(3'd7, 32'h8000_0000, 32'h0, 0);
        run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        run_op(3'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);

        // random operations
        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        // reset in the middle of a 20-step shift
        bus.start_valid = 1'b1;
        bus.in1 = 32'h0000_0ABC;
        bus.in2 = 32'd20;
        bus.alu_control = 3'd4;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.result_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_out", bus.out, 32'd0);
        check("mid_rst_zero", 32'(bus.zero_flag), 32'd1);
        check("mid_rst_start_ready", 32'(bus.start_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(3'd0, 32'd100, 32'd23, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Parameters
REQ-001 None; the data width SHALL be fixed at 32 and the shift-amount field at 5 bits.

Interface
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start_valid  input  1  the requester presents an operation.
REQ-005 start_ready  output  1  the unit can accept an operation (high only in IDLE).
REQ-006 in1  input  32  operand A, sampled on the accept edge.
REQ-007 in2  input  32  operand B; for shifts, in2[4:0] is the amount and in2[31:5] is ignored.
REQ-008 alu_control  input  3  opcode: 0 ADD, 1 COMP, 2 AND, 3 XOR, 4 SLL, 5 SRL, 6 SRA, 7 DIFF.
REQ-009 result_valid  output  1  the result and flags are valid (high only in DONE).
REQ-010 result_ready  input  1  the consumer takes the result.
REQ-011 out  output  32  registered result.
REQ-012 zero_flag  output  1  registered; high when out == 0.
REQ-013 msb_flag  output  1  registered; equals out[31].
REQ-014 carry_flag  output  1  registered; per REQ-024.
REQ-015 busy  output  1  high in EXEC or DONE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-017 Accept SHALL occur on an edge where start_valid && start_ready; the unit SHALL latch in1, in2, alu_control and go IDLE->EXEC.
REQ-018 Single-cycle ops (ADD, COMP, AND, XOR) SHALL compute on the first EXEC edge and go to DONE: result_valid high 1 edge after accept.
REQ-019 Shifts SHALL load count = in2[4:0] and move one bit per EXEC edge while count > 0, decrementing count; the edge with count == 0 SHALL go to DONE: result_valid high n+1 edges after accept; n = 0 passes in1 unchanged after 1 edge.
REQ-020 SRL and SLL SHALL zero-fill; SRA SHALL replicate bit 31.
REQ-021 DIFF SHALL scan index i = 0..31, one bit per EXEC edge, and stop at the first i where in1[i] != in2[i], with out = i and a latency of i+1 edges.
REQ-022 If DIFF finds no differing bit by i = 31, it SHALL give out = 32 after 32 edges.
REQ-023 ADD SHALL compute in1+in2 mod 2^32; COMP SHALL compute (~in2)+1; AND SHALL compute in1&in2; XOR SHALL compute in1^in2.
REQ-024 carry_flag SHALL be:
- ADD: carry out of bit 31.
- COMP: 1 iff in2 == 0.
- Shifts: the last bit shifted out, or 0 if n = 0.
- AND, XOR, DIFF: 0.
REQ-025 out and all flags SHALL update only on the transition into DONE and SHALL stay stable while in DONE.
REQ-026 In DONE, result_valid SHALL hold until result_valid && result_ready; on that edge the unit SHALL go DONE->IDLE.
REQ-027 No new accept SHALL occur on the same edge as the handshake in REQ-026, because start_ready is low in DONE.
REQ-028 start_valid SHALL be ignored outside IDLE; operand or opcode changes after accept SHALL NOT affect the operation in flight.
REQ-029 result_ready asserted outside DONE SHALL have no effect.

Reset
REQ-030 While rst is high, asynchronously:
- state = IDLE
- out = 0
- zero_flag = 1
- msb_flag = 0, carry_flag = 0
- result_valid = 0, busy = 0
- start_ready = 1
REQ-031 A reset asserted mid-EXEC or in DONE SHALL abort the operation and discard the result.
REQ-032 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 ADD in1=8, in2=9 -> after 1 edge: out=17, zero=0, msb=0, carry=0.
REQ-034 ADD in1=0xFFFFFFFF, in2=1 -> out=0, zero=1, carry=1; COMP in2=5 -> out=0xFFFFFFFB, msb=1, carry=0.
REQ-035 SLL in1=1023, in2=3 -> result_valid after exactly 4 edges, out=8184, carry=0; SRA in1=0xFD0F5DAA, in2=5 -> after 6 edges, out=0xFFE87AED, msb=1, carry=0.
REQ-036 DIFF in1=13, in2=11 -> after 2 edges, out=1; DIFF in1=in2=7 -> after 32 edges, out=32.
REQ-037 Backpressure: hold result_ready=0 for 10 cycles after result_valid -> out, flags and result_valid stay constant and start_ready stays 0; on the handshake edge -> next cycle is IDLE and start_ready=1.
REQ-038 Reset mid-operation: start SLL with n=20 and assert rst on cycle 5 -> immediately result_valid=0, busy=0, out=0, zero_flag=1; a new ADD issued after release completes normally.
